// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared constants for the shift-subtract divider (Control
//                and datapath agree on the ALU function codes and width).
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int          DEFAULT_WIDTH = 32;
    localparam logic [5:0]  FUNCT_ADD     = 6'b100000;
    localparam logic [5:0]  FUNCT_SUB     = 6'b100010;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_alu.sv
`default_nettype none
// ============================================================================
//  Module      : div_alu
//  Description : Combinational (WIDTH+1)-bit add / subtract / pass unit.
//                Add and subtract zero-extend the low WIDTH bits of the
//                remainder-high operand so bit WIDTH of the result is the sign.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_alu
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       funct,
    output logic [WIDTH:0]   y
);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;

    assign w_a_ext = {1'b0, a[WIDTH-1:0]};
    assign w_b_ext = {1'b0, b};

    // Select the operation; unknown codes return the operand untouched
    always_comb begin
        y = a;
        case (funct)
            FUNCT_ADD: y = w_a_ext + w_b_ext;
            FUNCT_SUB: y = w_a_ext - w_b_ext;
            default:   y = a;
        endcase
    end

endmodule : div_alu
`default_nettype wire

// File: rtl/divider_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : divider_datapath
//  Description : Register file and ALU for the restoring shift-subtract
//                unsigned divider. Executes one command from Control per
//                clock and reports the sign of the last subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             w_ctrl_reg1,
    input  logic             w_ctrl_reg2,
    input  logic [5:0]       funct,
    input  logic             SLL_ctrl,
    input  logic             SRL_ctrl,
    input  logic             rdy,
    output logic             rem_neg,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] r_div;
    logic [2*WIDTH:0] r_rem;
    logic             r_neg;
    logic             r_dbz;
    logic             r_out_valid;
    logic [WIDTH:0]   w_alu;

    div_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a     (r_rem[2*WIDTH:WIDTH]),
        .b     (r_div),
        .funct (funct),
        .y     (w_alu)
    );

    // One prioritised command per edge: load, hold on rdy, ALU write, shifts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div       <= '0;
            r_rem       <= '0;
            r_neg       <= 1'b0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_ctrl_reg1) begin
            r_div       <= divisor;
            r_rem       <= {{(WIDTH+1){1'b0}}, dividend};
            r_neg       <= 1'b0;
            r_dbz       <= (divisor == '0);
            r_out_valid <= 1'b0;
        end else if (rdy) begin
            r_out_valid <= 1'b1;
        end else if (w_ctrl_reg2) begin
            r_rem[2*WIDTH:WIDTH] <= w_alu;
            // Only a subtraction answers the "R_hi < D" question for Control
            if (funct == FUNCT_SUB) begin
                r_neg <= w_alu[WIDTH];
            end
        end else if (SLL_ctrl) begin
            // The inverted sign of the last SUB is the next quotient bit
            r_rem <= {r_rem[2*WIDTH-1:0], ~r_neg};
        end else if (SRL_ctrl) begin
            r_rem[2*WIDTH:WIDTH] <= {1'b0, r_rem[2*WIDTH:WIDTH+1]};
        end
    end

    assign rem_neg     = r_neg;
    assign quotient    = r_rem[WIDTH-1:0];
    assign remainder   = r_rem[2*WIDTH-1:WIDTH];
    assign div_by_zero = r_dbz;
    assign out_valid   = r_out_valid;

endmodule : divider_datapath
`default_nettype wire
